// File: rtl/collector_pkg.sv
// Shared types and default sizing for the generator stream collector.
package collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

endpackage

// File: rtl/collector_fifo.sv
// Synchronous tuple FIFO: registered pointers/count, head entry shown without bypass.
module collector_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("collector_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Empty forces zero so stale memory never leaks onto the read port.
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/generator_stream_collector.sv
// Runs one generator invocation per cmd_start, buffering its 4-field tuples for a consumer.
// Optional tuple_count output enabled by defining COLLECTOR_TUPLE_COUNT_EN.
module generator_stream_collector
    import collector_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                         _clock,
    input  logic                         _reset_n,
    input  logic                         cmd_start,
    output logic                         gen_start,
    input  logic signed [DATA_WIDTH-1:0] gen_out0,
    input  logic signed [DATA_WIDTH-1:0] gen_out1,
    input  logic signed [DATA_WIDTH-1:0] gen_out2,
    input  logic signed [DATA_WIDTH-1:0] gen_out3,
    input  logic                         gen_valid,
    output logic                         gen_ready,
    input  logic                         gen_done,
    output logic signed [DATA_WIDTH-1:0] rd_data0,
    output logic signed [DATA_WIDTH-1:0] rd_data1,
    output logic signed [DATA_WIDTH-1:0] rd_data2,
    output logic signed [DATA_WIDTH-1:0] rd_data3,
    output logic                         rd_valid,
    input  logic                         rd_ready,
`ifdef COLLECTOR_TUPLE_COUNT_EN
    output logic [15:0]                  tuple_count,
`endif
    output logic                         busy,
    output logic                         done
);
    localparam int TW = 4 * DATA_WIDTH;

    state_e                   state_q, state_d;
    logic                     gen_start_q, gen_start_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     fifo_full, fifo_empty, gen_push;
    logic [TW-1:0]            fifo_rdata;
    logic [$clog2(DEPTH):0]   fifo_count;

    assign gen_ready = (state_q == ST_COLLECT) && !fifo_full;
    assign gen_push  = gen_valid && gen_ready;
    assign rd_valid  = !fifo_empty;
    assign rd_data0  = fifo_rdata[0*DATA_WIDTH +: DATA_WIDTH];
    assign rd_data1  = fifo_rdata[1*DATA_WIDTH +: DATA_WIDTH];
    assign rd_data2  = fifo_rdata[2*DATA_WIDTH +: DATA_WIDTH];
    assign rd_data3  = fifo_rdata[3*DATA_WIDTH +: DATA_WIDTH];
    assign gen_start = gen_start_q;
    assign busy      = busy_q;
    assign done      = done_q;

    collector_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (_clock),
        .rst_n (_reset_n),
        .push  (gen_push),
        .wdata ({gen_out3, gen_out2, gen_out1, gen_out0}),
        .pop   (rd_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:    if (cmd_start) state_d = ST_START;
            ST_START:   state_d = ST_COLLECT;
            ST_COLLECT: if (gen_done) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (fifo_count == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        gen_start_d = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q     <= ST_IDLE;
            gen_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_start_q <= gen_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef COLLECTOR_TUPLE_COUNT_EN
    logic [15:0] tuple_count_q, tuple_count_d;

    always_comb begin
        tuple_count_d = tuple_count_q;
        if (state_q == ST_IDLE && cmd_start) begin
            tuple_count_d = '0;
        end else if (gen_push && tuple_count_q != 16'hFFFF) begin
            tuple_count_d = tuple_count_q + 16'd1;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) tuple_count_q <= '0;
        else           tuple_count_q <= tuple_count_d;
    end

    assign tuple_count = tuple_count_q;
`endif

endmodule

// File: doc/generator_stream_collector.md
GENERATOR_STREAM_COLLECTOR -- requirements
Module: generator_stream_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed width of each output tuple field.
REQ-002 SHALL have parameter DEPTH, default 8, tuple FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have port _clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port _reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_start, input, 1, request to run one generator invocation.
REQ-006 SHALL have port gen_start, output, 1, start pulse to the generator.
REQ-007 SHALL have ports gen_out0..gen_out3, input, DATA_WIDTH each, signed, the generator tuple fields.
REQ-008 SHALL have ports gen_valid (input, 1), gen_ready (output, 1) and gen_done (input, 1), forming the generator tuple handshake and end flag.
REQ-009 SHALL have ports rd_data0..rd_data3 (output, DATA_WIDTH each, signed), rd_valid (output, 1) and rd_ready (input, 1), forming the consumer read port.
REQ-010 SHALL have port busy, output, 1, high from accepted cmd_start until the run completes.
REQ-011 SHALL have port done, output, 1, single-cycle pulse at run completion.

Function
REQ-012 SHALL implement an FSM with states IDLE, START, COLLECT and DRAIN.
REQ-013 IDLE: cmd_start=1 moves the FSM to START; cmd_start is ignored in every other state.
REQ-014 START: gen_start=1 for exactly one cycle, then the FSM moves to COLLECT.
REQ-015 COLLECT: gen_ready = !fifo_full; a tuple is pushed when gen_valid && gen_ready.
REQ-016 COLLECT: gen_done=1 moves the FSM to DRAIN; a tuple presented in the same cycle with gen_valid && gen_ready is still pushed.
REQ-017 DRAIN: gen_ready=0; when the FIFO is empty, done=1 for one cycle and the FSM moves to IDLE.
REQ-018 busy SHALL be 1 in START, COLLECT and DRAIN, and 0 in IDLE.
REQ-019 Outside COLLECT, gen_ready SHALL be 0.
REQ-020 Read side: rd_valid = !fifo_empty; rd_data0..3 are the head tuple; a pop occurs when rd_valid && rd_ready.
REQ-021 Latency: a pushed tuple SHALL become visible at rd_data on the next cycle; there is no combinational bypass.
REQ-022 Push and pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-023 Full: gen_ready=0; a tuple held by the generator SHALL not be lost and is accepted on the first non-full cycle.
REQ-024 Empty: rd_valid=0, and rd_ready is ignored.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 The count SHALL be log2(DEPTH)+1 bits.
REQ-027 Tuple fields SHALL be stored bit-exact with no sign or width change.

Reset
REQ-028 Asserting _reset_n=0 SHALL immediately force the FSM to IDLE and clear pointers and count.
REQ-029 During reset, gen_start, gen_ready, rd_valid, busy and done SHALL all be 0; rd_data0..3 SHALL be 0.
REQ-030 Reset mid-run SHALL discard buffered tuples, and no done pulse SHALL be generated.
REQ-031 After deassertion, the block SHALL wait in IDLE for cmd_start.

Configuration
REQ-032 Macro COLLECTOR_TUPLE_COUNT_EN defined: adds output tuple_count, 16 bits, counting tuples pushed in the current run.
REQ-033 tuple_count SHALL clear on START, saturate at 16'hFFFF, hold after done, and be 0 on reset.
REQ-034 Macro undefined: the tuple_count port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package collector_pkg SHALL hold the FSM state enum and the default DATA_WIDTH and DEPTH constants.
REQ-036 Sub-module collector_fifo SHALL hold a synchronous FIFO of width 4*DATA_WIDTH and depth DEPTH, with push/pop, full/empty and count.

Verification
REQ-037 Basic: cmd_start, then the generator gives (3,4,0,0) then (-5,7,0,0) then gen_done -> gen_start for 1 cycle, both tuples read in order, done pulse, busy low.
REQ-038 Backpressure: DEPTH=8 with rd_ready=0 and 10 tuples offered -> gen_ready low after 8 pushes; after release, all 10 are read in order with none lost.
REQ-039 Simultaneous: push and pop every cycle with a half-full FIFO for 20 cycles -> count is constant at 4 and data order is preserved across pointer wrap.
REQ-040 Done and valid together: the final tuple arrives with gen_done=1 -> it is stored and read, and done fires only after it is popped.
REQ-041 Reset mid-run: _reset_n low with 3 tuples buffered -> rd_valid=0, busy=0, no done pulse; a following run operates normally.
REQ-042 Counter build: with COLLECTOR_TUPLE_COUNT_EN, a run of 5 tuples -> tuple_count=5 at done, and it clears to 0 on the next START.
